// File: rtl/header_pkg.sv
// Shared definitions for the data bus arbiter: memory map, FSM states and
// load/store size encodings (RISC-V funct3).
package header_pkg;

    localparam logic [31:0] DMEM_BASE  = 32'h8000_0000;
    localparam logic [31:0] DMEM_LIMIT = 32'h8000_00FF;
    localparam logic [31:0] UART_BASE  = 32'h8000_0200;
    localparam logic [31:0] UART_LIMIT = 32'h8000_02FF;

    localparam logic [2:0] SIZE_BYTE   = 3'b000;
    localparam logic [2:0] SIZE_HALF   = 3'b001;
    localparam logic [2:0] SIZE_WORD   = 3'b010;
    localparam logic [2:0] SIZE_BYTE_U = 3'b100;
    localparam logic [2:0] SIZE_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        UART_WAIT,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_DMEM,
        REGION_UART
    } region_t;

endpackage

// File: rtl/addr_region_decode.sv
// Combinational address decoder: selects the slave region, computes the
// region-relative offset and flags accesses misaligned for their size.
module addr_region_decode
    import header_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    output region_t     region,
    output logic [31:0] offset,
    output logic        misaligned
);

    always_comb begin
        region = REGION_NONE;
        offset = '0;
        if (addr >= DMEM_BASE && addr <= DMEM_LIMIT) begin
            region = REGION_DMEM;
            offset = addr - DMEM_BASE;
        end else if (addr >= UART_BASE && addr <= UART_LIMIT) begin
            region = REGION_UART;
            offset = addr - UART_BASE;
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_HALF, SIZE_HALF_U: misaligned = addr[0];
            SIZE_WORD:              misaligned = (addr[1:0] != 2'b00);
            default:                misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master (CPU, DMA) to two-slave (data memory, UART) bus arbiter with
// round-robin grant, address decode, UART ready/timeout handling.
module data_bus_arbiter
    import header_pkg::*;
#(
    parameter int UART_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_size,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [2:0]  dma_size,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic        dma_err,
    output logic        dmem_wr_en,
    output logic        dmem_rd_en,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [2:0]  dmem_size,
    input  logic [31:0] dmem_rdata,
    output logic        uart_wr_en,
    output logic        uart_rd_en,
    output logic [31:0] uart_addr,
    output logic [31:0] uart_wdata,
    input  logic [31:0] uart_rdata,
    input  logic        uart_ready
);

    localparam logic [31:0] TIMEOUT_CNT = 32'(UART_TIMEOUT);

    arb_state_t  state_reg, state_next;
    logic        grant_dma_reg, grant_dma_next;
    logic        last_dma_reg;
    logic        we_reg;
    logic [31:0] addr_reg, wdata_reg, rdata_reg, count_reg;
    logic [2:0]  size_reg;
    logic        err_reg;

    region_t     region;
    logic [31:0] offset;
    logic        misaligned;
    logic        strobe, capture, resp_err;
    logic [31:0] resp_data;

    addr_region_decode u_decode (
        .addr       (addr_reg),
        .size       (size_reg),
        .region     (region),
        .offset     (offset),
        .misaligned (misaligned)
    );

    // Rotation only advances on contested grants, so an uncontested grant
    // does not rob the other master of its turn at the next collision.
    always_comb begin
        if (cpu_req && dma_req)
            grant_dma_next = ~last_dma_reg;
        else
            grant_dma_next = dma_req;
    end

    always_comb begin
        state_next = state_reg;
        strobe     = 1'b0;
        capture    = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;
        case (state_reg)
            IDLE: begin
                if (cpu_req || dma_req)
                    state_next = ACCESS;
            end
            ACCESS: begin
                if (region == REGION_NONE || misaligned) begin
                    capture    = 1'b1;
                    resp_err   = 1'b1;
                    state_next = RESP;
                end else if (region == REGION_DMEM) begin
                    strobe     = 1'b1;
                    capture    = 1'b1;
                    resp_data  = we_reg ? '0 : dmem_rdata;
                    state_next = RESP;
                end else if (uart_ready) begin
                    strobe     = 1'b1;
                    capture    = 1'b1;
                    resp_data  = we_reg ? '0 : uart_rdata;
                    state_next = RESP;
                end else begin
                    state_next = UART_WAIT;
                end
            end
            UART_WAIT: begin
                if (count_reg == TIMEOUT_CNT) begin
                    capture    = 1'b1;
                    resp_err   = 1'b1;
                    state_next = RESP;
                end else if (uart_ready) begin
                    strobe     = 1'b1;
                    capture    = 1'b1;
                    resp_data  = we_reg ? '0 : uart_rdata;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            grant_dma_reg <= 1'b0;
            last_dma_reg  <= 1'b1;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            size_reg      <= '0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && (cpu_req || dma_req)) begin
                grant_dma_reg <= grant_dma_next;
                if (cpu_req && dma_req)
                    last_dma_reg <= grant_dma_next;
                we_reg    <= grant_dma_next ? dma_we    : cpu_we;
                addr_reg  <= grant_dma_next ? dma_addr  : cpu_addr;
                wdata_reg <= grant_dma_next ? dma_wdata : cpu_wdata;
                size_reg  <= grant_dma_next ? dma_size  : cpu_size;
            end
            if (state_reg == ACCESS)
                count_reg <= '0;
            else if (state_reg == UART_WAIT)
                count_reg <= count_reg + 32'd1;
            if (capture) begin
                rdata_reg <= resp_data;
                err_reg   <= resp_err;
            end
        end
    end

    always_comb begin
        dmem_rd_en = strobe && (region == REGION_DMEM) && !we_reg;
        dmem_wr_en = strobe && (region == REGION_DMEM) && we_reg;
        uart_rd_en = strobe && (region == REGION_UART) && !we_reg;
        uart_wr_en = strobe && (region == REGION_UART) && we_reg;
        dmem_addr  = (region == REGION_DMEM) ? offset    : '0;
        dmem_wdata = (region == REGION_DMEM) ? wdata_reg : '0;
        dmem_size  = size_reg;
        uart_addr  = (region == REGION_UART) ? offset    : '0;
        uart_wdata = (region == REGION_UART) ? wdata_reg : '0;
    end

    always_comb begin
        cpu_done  = (state_reg == RESP) && !grant_dma_reg;
        dma_done  = (state_reg == RESP) && grant_dma_reg;
        cpu_err   = cpu_done && err_reg;
        dma_err   = dma_done && err_reg;
        cpu_rdata = cpu_done ? rdata_reg : '0;
        dma_rdata = dma_done ? rdata_reg : '0;
        cpu_stall = cpu_req && !cpu_done;
    end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 SHALL have parameter UART_TIMEOUT, default 255, max cycles waiting on uart_ready before error response.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports cpu_req/cpu_we  input  1 each  CPU memory-stage request, write-enable.
REQ-005 SHALL have ports cpu_addr/cpu_wdata  input  32 each, and cpu_size  input  3  (funct3 load/store size).
REQ-006 SHALL have ports cpu_rdata  output  32; cpu_done, cpu_err, cpu_stall  output  1 each.
REQ-007 SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_size, dma_rdata, dma_done, dma_err with the same widths and meanings as the cpu_* ports (no stall).
REQ-008 SHALL have ports dmem_wr_en, dmem_rd_en  output  1; dmem_addr  output  32 (region offset); dmem_wdata  output  32; dmem_size  output  3; dmem_rdata  input  32.
REQ-009 SHALL have ports uart_wr_en, uart_rd_en  output  1; uart_addr  output  32 (offset); uart_wdata  output  32; uart_rdata  input  32; uart_ready  input  1.

Function
REQ-010 SHALL decode regions: data 0x8000_0000-0x8000_00FF, UART 0x8000_0200-0x8000_02FF; all other addresses (including instruction space 0x0-0x3E7) are unmapped.
REQ-011 SHALL implement FSM states IDLE, ACCESS, UART_WAIT, RESP.
REQ-012 SHALL, in IDLE with any req high, grant one requester, latch its we/addr/wdata/size and move to ACCESS next edge.
REQ-013 SHALL arbitrate round-robin when both requests are high: grant the requester not granted last; after reset CPU wins first.
REQ-014 SHALL, in ACCESS to data region, assert dmem_rd_en or dmem_wr_en for exactly one cycle with offset address, capture dmem_rdata, go to RESP.
REQ-015 SHALL, in ACCESS to UART region with uart_ready high, strobe uart_rd_en/uart_wr_en one cycle, capture uart_rdata, go to RESP; with uart_ready low, go to UART_WAIT.
REQ-016 SHALL, in UART_WAIT, count cycles; strobe on first uart_ready high then RESP; at count == UART_TIMEOUT go to RESP with error, no strobe.
REQ-017 SHALL flag error, with no slave strobe, for unmapped address or misalignment (half: addr[0]!=0; word: addr[1:0]!=0).
REQ-018 SHALL, in RESP, pulse done for one cycle to the granted requester only, with registered rdata (0 on error or write) and err, then return to IDLE.
REQ-019 SHALL give 2-cycle latency, req sampled to done, for error-free data-region and ready-UART accesses.
REQ-020 SHALL drive cpu_stall = cpu_req AND NOT cpu_done combinationally.
REQ-021 SHALL treat requesters as holding req and payload stable until done; a req still high in IDLE after RESP is a new request.
REQ-022 SHALL ignore payload changes after the latch edge; a request arriving during a busy transaction waits in its req line.

Reset
REQ-023 SHALL, on reset low, asynchronously force IDLE, clear latched request, counter, and rdata registers, set last-grant to DMA, and drive all outputs to 0.
REQ-024 SHALL abort any in-flight transaction on reset without issuing done, including in UART_WAIT.

Structure
REQ-025 SHALL place region base/limit constants, the arb_state_t enum, and size encodings (byte/half/word/byte-u/half-u) in header_pkg.
REQ-026 SHALL instantiate one combinational sub-module addr_region_decode (addr, size -> region, offset, misaligned).

Verification
REQ-027 CPU word read 0x8000_0010, dmem_rdata=0xDEADBEEF -> dmem_rd_en pulse 1 cycle, addr 0x10, cpu_done 2 cycles later, cpu_rdata=0xDEADBEEF, stall high until then.
REQ-028 CPU and DMA req same cycle after reset -> CPU served first, DMA done 3 cycles later; repeat both -> DMA first.
REQ-029 DMA write 0x8000_0204, uart_ready low 10 cycles -> uart_wr_en single pulse on 11th ready cycle, dma_done next, dma_err=0.
REQ-030 CPU read 0x8000_0200, uart_ready stuck low, UART_TIMEOUT=4 -> no strobe, cpu_done with cpu_err=1, rdata=0.
REQ-031 CPU word write 0x8000_0002 and read 0x0000_0100 -> no strobes, cpu_err=1 each, done at 2 cycles.
REQ-032 Reset low in UART_WAIT -> outputs 0 immediately, no done; next request after release served by CPU-first rule.
